// File: rtl/qupdate_ctrl.sv
// qupdate_ctrl: one Q-learning update per request: read Q(s,a) and the s' row, take the max,
// compute Q' = Q + alpha*(r + gamma*maxQ - Q) with shift-based alpha/gamma, write Q' back.
// Define QUPD_SAT_EN to clamp Q' to the signed DATA_WIDTH range instead of wrapping.
module qupdate_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_W     = 6,
    parameter int ACTION_W    = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    input  logic [STATE_W-1:0]    i_state,
    input  logic [ACTION_W-1:0]   i_action,
    input  logic [STATE_W-1:0]    i_next_state,
    input  logic [DATA_WIDTH-1:0] i_reward,
    output logic [ADDR_WIDTH-1:0] o_q_addr_r,
    output logic                  o_q_read_en,
    input  logic [DATA_WIDTH-1:0] i_q_data,
    output logic [ADDR_WIDTH-1:0] o_q_addr_w,
    output logic                  o_q_write_en,
    output logic [DATA_WIDTH-1:0] o_q_data,
    output logic                  o_done
);

    localparam int WW = DATA_WIDTH + 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_DRAIN = 3'd2,
        S_CALC  = 3'd3,
        S_WR    = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     rd_cnt_q, rd_cnt_d;
    logic [STATE_W-1:0]             s_q, s_d;
    logic [ACTION_W-1:0]            a_q, a_d;
    logic [STATE_W-1:0]             sp_q, sp_d;
    logic signed [DATA_WIDTH-1:0]   r_q, r_d;
    logic signed [DATA_WIDTH-1:0]   qcur_q, qcur_d;
    logic signed [DATA_WIDTH-1:0]   max_q, max_d;
    logic                           cap_vld_q, cap_vld_d;
    logic [2:0]                     cap_idx_q, cap_idx_d;
    logic                           ready_q, ready_d;
    logic                           rd_en_q, rd_en_d;
    logic                           wr_en_q, wr_en_d;
    logic                           done_q, done_d;
    logic [ADDR_WIDTH-1:0]          addr_r_q, addr_r_d;
    logic [ADDR_WIDTH-1:0]          addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;

    logic                           accept;
    logic signed [WW-1:0]           max_w, q_w, r_w, g_w, td_w;

    assign accept = (state_q == S_IDLE) && i_upd_valid;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RD;
            S_RD:    if (rd_cnt_q == 3'd4) state_d = S_DRAIN;
            S_DRAIN: state_d = S_CALC;
            S_CALC:  state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: request latch, read sequencing, capture, max and Q' arithmetic
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        s_d       = s_q;
        a_d       = a_q;
        sp_d      = sp_q;
        r_d       = r_q;
        qcur_d    = qcur_q;
        max_d     = max_q;
        data_d    = data_q;
        cap_vld_d = (state_q == S_RD);
        cap_idx_d = rd_cnt_q;

        if (accept) begin
            rd_cnt_d = '0;
            s_d      = i_state;
            a_d      = i_action;
            sp_d     = i_next_state;
            r_d      = i_reward;
        end else if (state_q == S_RD) begin
            rd_cnt_d = rd_cnt_q + 3'd1;
        end

        // Read data lags its read by one cycle; index 0 is Q(s,a), 1..4 are the s' row
        if (cap_vld_q) begin
            if (cap_idx_q == 3'd0) begin
                qcur_d = i_q_data;
            end else if (cap_idx_q == 3'd1) begin
                max_d = i_q_data;
            end else if ($signed(i_q_data) > max_q) begin
                max_d = i_q_data;
            end
        end

        max_w = {{3{max_q[DATA_WIDTH-1]}}, max_q};
        q_w   = {{3{qcur_q[DATA_WIDTH-1]}}, qcur_q};
        r_w   = {{3{r_q[DATA_WIDTH-1]}}, r_q};
        g_w   = max_w - (max_w >>> GAMMA_SHIFT);
        td_w  = r_w + g_w - q_w;

        if (state_q == S_CALC) begin
`ifdef QUPD_SAT_EN
            data_d = sat_q(q_w + (td_w >>> ALPHA_SHIFT));
`else
            data_d = DATA_WIDTH'(q_w + (td_w >>> ALPHA_SHIFT));
`endif
        end
    end

`ifdef QUPD_SAT_EN
    localparam logic signed [WW-1:0] Q_MAX = {{4{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] Q_MIN = {{4{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] sat_q(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] c;
        c = v;
        if (v > Q_MAX) c = Q_MAX;
        else if (v < Q_MIN) c = Q_MIN;
        return c[DATA_WIDTH-1:0];
    endfunction
`endif

    // Output logic, registered from next state so the ports are glitch-free
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        rd_en_d  = (state_d == S_RD);
        wr_en_d  = (state_d == S_WR);
        done_d   = (state_d == S_WR);
        addr_r_d = addr_r_q;
        addr_w_d = addr_w_q;
        if (accept) begin
            addr_r_d = {i_state, i_action};
        end else if (state_q == S_RD && state_d == S_RD) begin
            addr_r_d = {sp_q, rd_cnt_q[ACTION_W-1:0]};
        end
        if (state_d == S_WR) begin
            addr_w_d = {s_q, a_q};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            s_q       <= '0;
            a_q       <= '0;
            sp_q      <= '0;
            r_q       <= '0;
            qcur_q    <= '0;
            max_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            ready_q   <= 1'b1;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            addr_r_q  <= '0;
            addr_w_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            s_q       <= s_d;
            a_q       <= a_d;
            sp_q      <= sp_d;
            r_q       <= r_d;
            qcur_q    <= qcur_d;
            max_q     <= max_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            ready_q   <= ready_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            addr_r_q  <= addr_r_d;
            addr_w_q  <= addr_w_d;
            data_q    <= data_d;
        end
    end

    assign o_upd_ready  = ready_q;
    assign o_q_read_en  = rd_en_q;
    assign o_q_write_en = wr_en_q;
    assign o_done       = done_q;
    assign o_q_addr_r   = addr_r_q;
    assign o_q_addr_w   = addr_w_q;
    assign o_q_data     = data_q;

endmodule
